// File: rtl/tpu_c_drain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : tpu_pkg                                                      |
// | Description : Shared defaults and types for the TPU C-matrix drain path.   |
// |               Holds the array/word geometry defaults, the drain FSM state  |
// |               type and a small width helper used by the drain modules.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package tpu_pkg;

  localparam int DIM_DFLT        = 8;   // systolic array dimension
  localparam int BITS_C_DFLT     = 16;  // accumulator element width
  localparam int DATAW_DFLT      = 64;  // host word width
  localparam int FIFO_DEPTH_DFLT = 4;   // output buffer depth in words

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PUSH  = 2'd2,
    ST_FLUSH = 2'd3
  } drain_state_t;

  // Index width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_c_drain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : tpu_c_drain_if                                               |
// | Description : Valid/ready result stream from the C drain toward the host.  |
// |   out_data  : packed result word                                           |
// |   out_valid : out_data holds a word                                        |
// |   out_ready : host accepts the word (transfer on valid & ready at clk)     |
// |   out_last  : qualifies the final word of a matrix                         |
// |   master = drain side, slave = host side                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface tpu_c_drain_if
  import tpu_pkg::*;
#(
  parameter int DATAW = DATAW_DFLT
);

  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/tpu_c_drain_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tpu_word_fifo                                                |
// | Description : Registered show-ahead synchronous FIFO. A word written at    |
// |               edge t is visible on pop_data_o from cycle t+1. Pushes are   |
// |               refused when full even if a pop happens in the same cycle.   |
// |   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only) |
// |   push_i      : write push_data_i (ignored when full)                      |
// |   pop_i       : retire the head word (ignored when empty)                  |
// |   pop_data_o  : head word                                                  |
// |   count_o     : words held; full_o / empty_o status flags                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tpu_word_fifo
  import tpu_pkg::*;
#(
  parameter int WIDTH = DATAW_DFLT + 1,
  parameter int DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_push;
  logic             w_pop;

  // Wrapping increment that also works for non power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign w_push     = push_i & ~full_o;
  assign w_pop      = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Storage carries no reset; only the bookkeeping below does.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (w_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tpu_c_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tpu_c_drain                                                  |
// | Description : Unloads the systolic array's C matrix row by row, packs each |
// |               row into DATAW-bit words (lowest element in the low bits)    |
// |               and streams them to the host through a small FIFO, tagging   |
// |               the final word with out_last and pulsing done afterwards.    |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   start_i    : one-cycle unload request (ignored while busy / in done)     |
// |   crow_o     : row select toward the array's C read port                   |
// |   cout_i     : selected C row, combinationally valid                       |
// |   busy_o     : unload in progress                                          |
// |   done_o     : one-cycle pulse after the last word transfers               |
// |   out_if     : valid/ready result stream (master side)                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tpu_c_drain
  import tpu_pkg::*;
#(
  parameter int BITS_C     = BITS_C_DFLT,
  parameter int DIM        = DIM_DFLT,
  parameter int DATAW      = DATAW_DFLT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic [$clog2(DIM)-1:0]  crow_o,
  input  logic [BITS_C-1:0]       cout_i [DIM],
  output logic                    busy_o,
  output logic                    done_o,
  tpu_c_drain_if.master           out_if
);

  localparam int WPR = DIM * BITS_C / DATAW;   // words per row
  localparam int RW  = $clog2(DIM);
  localparam int WW  = clog2_min1(WPR);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  drain_state_t      state_q;
  logic [RW-1:0]     row_q;
  logic [WW-1:0]     word_q;
  logic              busy_q;
  logic              done_q;
  logic [BITS_C-1:0] rowreg_q [DIM];

  logic [DIM*BITS_C-1:0] w_row_flat;
  logic [DATAW-1:0]      w_words [WPR];
  logic                  w_last_tag;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [DATAW:0]        w_fifo_head;

  // Flatten the captured row so element i sits at bits [i*BITS_C +: BITS_C].
  for (genvar i = 0; i < DIM; i++) begin : g_flat
    assign w_row_flat[i*BITS_C +: BITS_C] = rowreg_q[i];
  end

  for (genvar w = 0; w < WPR; w++) begin : g_words
    assign w_words[w] = w_row_flat[w*DATAW +: DATAW];
  end

  assign w_last_tag = (row_q == RW'(DIM - 1)) && (word_q == WW'(WPR - 1));
  assign w_push     = (state_q == ST_PUSH) && !w_full;
  assign w_pop      = out_if.out_valid && out_if.out_ready;

  tpu_word_fifo #(
    .WIDTH (DATAW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .push_data_i ({w_last_tag, w_words[word_q]}),
    .pop_i       (w_pop),
    .pop_data_o  (w_fifo_head),
    .count_o     (w_count),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  assign out_if.out_valid = (w_count != '0);
  assign out_if.out_data  = w_fifo_head[DATAW-1:0];
  // Storage is not reset, so the tag is masked while nothing is presented.
  assign out_if.out_last  = w_fifo_head[DATAW] & ~w_empty;

  assign crow_o = row_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

  // Row register: captures the array row while crow_o points at it.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) begin
      rowreg_q <= cout_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The done cycle is already IDLE; a start there must not retrigger.
          if (start_i && !done_q) begin
            state_q <= ST_LOAD;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q <= ST_PUSH;
          word_q  <= '0;
        end
        ST_PUSH: begin
          if (!w_full) begin
            if (word_q == WW'(WPR - 1)) begin
              if (row_q == RW'(DIM - 1)) begin
                state_q <= ST_FLUSH;
              end else begin
                row_q   <= row_q + RW'(1);
                state_q <= ST_LOAD;
              end
            end else begin
              word_q <= word_q + WW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (w_pop && out_if.out_last) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tpu_c_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tpu_c_drain                                               |
// | Description : Self-checking bench for tpu_c_drain. A queue of expected     |
// |               words is built from the C matrix by plain packing arithmetic |
// |               and a negedge monitor compares every presented word, the     |
// |               last tag, hold-while-stalled and the done pulse timing.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tpu_c_drain;

  localparam int DIM    = 8;
  localparam int BITS_C = 16;
  localparam int DATAW  = 64;
  localparam int WPR    = DIM * BITS_C / DATAW;
  localparam int EPW    = DATAW / BITS_C;
  localparam int NW     = DIM * WPR;

  typedef struct packed {
    logic             last;
    logic [DATAW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [2:0]        crow;
  logic [BITS_C-1:0] cout [DIM];
  logic              busy;
  logic              done;
  logic [BITS_C-1:0] cmat [DIM][DIM];

  tpu_c_drain_if #(.DATAW(DATAW)) bus ();

  tpu_c_drain #(
    .BITS_C     (BITS_C),
    .DIM        (DIM),
    .DATAW      (DATAW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .crow_o  (crow),
    .cout_i  (cout),
    .busy_o  (busy),
    .done_o  (done),
    .out_if  (bus)
  );

  always #5 clk = ~clk;

  // The array read port: the selected row appears combinationally.
  always_comb begin
    for (int c = 0; c < DIM; c++) cout[c] = cmat[crow][c];
  end

  int               total = 0;
  int               bad   = 0;
  int               xfers = 0;
  int               rdy_mode = 0;    // 0: always ready, 1: random, 2: never
  bit               chk_en = 1'b0;
  bit               done_exp = 1'b0;
  bit               stall_prev = 1'b0;
  logic [DATAW-1:0] prev_data;
  logic [DATAW-1:0] first_word;
  logic [DATAW-1:0] last_word;
  exp_t             exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected word stream: row r, word w holds elements w*EPW .. w*EPW+EPW-1.
  task automatic load_model();
    for (int k = 0; k < NW; k++) begin
      exp_t e;
      int   r = k / WPR;
      int   w = k % WPR;
      e.data = '0;
      for (int j = 0; j < EPW; j++)
        e.data = e.data | (64'(cmat[r][w*EPW + j]) << (j * BITS_C));
      e.last = (k == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
    check("busy_in_done", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_unload();
    xfers = 0;
    start = 1'b1;
    load_model();
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    wait_done(2000);
    check("xfer_count", xfers, NW);
  endtask

  task automatic fill_random();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) cmat[r][c] = BITS_C'($urandom);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) cmat[r][c] = BITS_C'(r * 16 + c);
  endtask

  // Monitor: one look per cycle, half a period away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("done_pulse", done, done_exp);
      done_exp = 1'b0;
      if (stall_prev) begin
        check("valid_hold", bus.out_valid, 1);
        check("data_hold", bus.out_data, prev_data);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %h expected none at %0t", bus.out_data, $time);
        end else begin
          check("word", bus.out_data, exp_q[0].data);
          check("last", bus.out_last, exp_q[0].last);
          if (bus.out_ready) begin
            if (xfers == 0) first_word = bus.out_data;
            last_word = bus.out_data;
            if (exp_q[0].last) done_exp = 1'b1;
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end else begin
        check("last_idle", bus.out_last, 0);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.out_ready = 1'b0;
    fill_ramp();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_crow", crow, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Ramp matrix, host always ready.
    rdy_mode = 0;
    tick();
    do_unload();
    check("word0_lit", first_word, 64'h0003_0002_0001_0000);
    check("word15_lit", last_word, 64'h0077_0076_0075_0074);

    // Host stalled for 20 cycles: four words buffered, FSM parked on row 2.
    rdy_mode = 2;
    tick();
    xfers = 0;
    start = 1'b1;
    load_model();
    tick();
    start = 1'b0;
    repeat (19) tick();
    check("stall_crow", crow, 2);
    check("stall_valid", bus.out_valid, 1);
    check("stall_head", bus.out_data, 64'h0003_0002_0001_0000);
    tick();
    check("stall_crow_frozen", crow, 2);
    check("stall_busy", busy, 1);
    check("stall_no_xfer", xfers, 0);
    rdy_mode = 0;
    wait_done(2000);
    check("stall_xfers", xfers, NW);

    // Random matrices with random backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 3; t++) begin
      fill_random();
      tick();
      do_unload();
    end

    // Second start while busy is ignored.
    fill_random();
    tick();
    xfers = 0;
    start = 1'b1;
    load_model();
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2000);
    repeat (5) tick();
    check("restart_idle", busy, 0);
    check("restart_xfers", xfers, NW);

    // Reset after the fifth transfer, then a clean unload from row 0.
    rdy_mode = 0;
    fill_random();
    tick();
    xfers = 0;
    start = 1'b1;
    load_model();
    tick();
    start = 1'b0;
    n = 0;
    while (xfers < 5 && n < 200) begin
      tick();
      n++;
    end
    check("pre_reset_xfers", xfers, 5);
    rst_n  = 1'b0;
    chk_en = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_crow", crow, 0);
    exp_q.delete();
    done_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", done, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();
    do_unload();

    // Start held through the done cycle into the next one.
    fill_random();
    tick();
    do_unload();
    start = 1'b1;
    tick();
    check("done_cycle_start_ignored", busy, 0);
    xfers = 0;
    load_model();
    tick();
    start = 1'b0;
    check("b2b_accepted", busy, 1);
    wait_done(2000);
    check("b2b_xfers", xfers, NW);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tpu_c_drain.md
TPU_C_DRAIN -- requirements
Module: tpu_c_drain

Interface
REQ-001 Parameters: BITS_C, default 16, accumulator element width; DIM, default 8, array dimension; DATAW, default 64, host word width; FIFO_DEPTH, default 4, output buffer words.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to unload the full C matrix; ignored while busy=1.
REQ-005 crow  output  $clog2(DIM)  row select driven to the systolic array's C read port.
REQ-006 cout  input  DIM x BITS_C (unpacked)  C row selected by crow, valid combinationally in the same cycle.
REQ-007 out_data  output  DATAW  packed result word toward host.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_ready  input  1  host accepts word; transfer occurs when out_valid & out_ready at a rising edge.
REQ-010 out_last  output  1  qualifies the final word of the matrix.
REQ-011 busy  output  1  high from the cycle after accepted start until done.
REQ-012 done  output  1  single-cycle pulse when the last word has transferred.

Function
REQ-013 WPR = DIM*BITS_C/DATAW words per row (2 at defaults); DATAW/BITS_C elements per word; parameters with a non-integer WPR are illegal.
REQ-014 Word w of row r carries elements w*(DATAW/BITS_C) upward, lowest-index element in bits [BITS_C-1:0]; raw bits, no saturation or sign change.
REQ-015 FSM states: IDLE, LOAD, PUSH, FLUSH.
REQ-016 IDLE: crow=0, busy=0; start=1 -> LOAD, row counter=0.
REQ-017 LOAD (one cycle): capture cout into the DIM x BITS_C row register with crow = row counter -> PUSH, word counter=0.
REQ-018 PUSH: push word[word counter] when FIFO count < FIFO_DEPTH, else stall with no push; after word WPR-1 is pushed: if row counter = DIM-1 -> FLUSH, else increment row counter -> LOAD.
REQ-019 A push is blocked whenever count = FIFO_DEPTH, even in a cycle with a simultaneous pop.
REQ-020 The FIFO is registered show-ahead: a word pushed at edge t is presented on out_data/out_valid from cycle t+1.
REQ-021 Simultaneous push and pop with count < FIFO_DEPTH: count unchanged, ordering preserved.
REQ-022 out_valid=0 whenever the FIFO is empty; out_data is don't-care then.
REQ-023 out_last=1 only while the presented word is word DIM*WPR-1 of the current unload; it is carried through the FIFO as a tag bit.
REQ-024 FLUSH: wait until the out_last word transfers, then pulse done=1 for exactly the following cycle and enter IDLE (busy=0 in that cycle).
REQ-025 Unload cost: (1+WPR) cycles per row without backpressure; 16 words per matrix at defaults.
REQ-026 start asserted while busy=1, including in the done cycle, has no effect.
REQ-027 out_data and out_last hold stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst_n low asynchronously forces IDLE, row/word counters=0, FIFO count=0, crow=0, out_valid=0, out_last=0, busy=0, done=0; the row register and FIFO storage are not reset.
REQ-029 Reset mid-unload discards all buffered words; no done pulse is emitted; the next start begins again at row 0.

Structure
REQ-030 Package tpu_pkg holds DIM, BITS_C, DATAW defaults and the drain_state_t enum.
REQ-031 One sub-module, tpu_word_fifo: parameterised synchronous FIFO with width DATAW+1 and depth FIFO_DEPTH, exposing count/full/empty.

Verification
REQ-032 C[r][c] = r*16+c, start pulse, out_ready=1 -> 16 transfers; word0 = 0x0003_0002_0001_0000; word15 = 0x0077_0076_0075_0074 with out_last=1; done exactly one cycle after word15 transfers.
REQ-033 out_ready=0 for 20 cycles after start -> FIFO holds 4 words, FSM stalls in PUSH, crow frozen, no word lost or duplicated; release -> remaining order intact.
REQ-034 Random out_ready toggling (50%) -> the 16-word sequence matches the reference packing; out_data stable while stalled.
REQ-035 Second start pulse mid-unload -> ignored; exactly 16 words and one done pulse.
REQ-036 rst_n low after the 5th transfer -> out_valid=0 and busy=0 immediately; a new start yields the full 16 words beginning with row 0.
REQ-037 Back-to-back: start asserted in the cycle after done -> second unload is accepted and completes normally.
